// File: rtl/fifo_flush_pkg.sv
// rtl/fifo_flush_pkg.sv - shared FSM states, flush modes and sizing helper for the flush/pack FIFO
package fifo_flush_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PAD  = 2'd1,
    ST_DONE = 2'd2,
    ST_HOLD = 2'd3
  } flush_state_e;

  localparam logic FLUSH_COMMIT  = 1'b0;
  localparam logic FLUSH_DISCARD = 1'b1;

  // Read/write pointers carry one extra wrap bit above the entry index
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_pack_mem.sv
// rtl/fifo_pack_mem.sv - first-word-fall-through word storage with wrap-bit pointers and synchronous clear
module fifo_pack_mem
  import fifo_flush_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 8,
  localparam int PTR_W = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [PTR_W-1:0] count_o
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                     (wr_ptr_q[PTR_W-2:0] == rd_ptr_q[PTR_W-2:0]);
  assign count_o   = wr_ptr_q - rd_ptr_q;
  assign rd_data_o = mem_q[rd_ptr_q[PTR_W-2:0]];

  // Qualify push/pop; a push into a full FIFO is allowed only when the head leaves at the same edge
  always_comb begin
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full_o || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (do_push) begin
        mem_d[wr_ptr_q[PTR_W-2:0]] = push_data_i;
        wr_ptr_d                   = wr_ptr_q + PTR_W'(1);
      end
    end
  end

  // Pointer and storage registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/fifo_flush_pack.sv
// rtl/fifo_flush_pack.sv - narrow-to-wide beat packer with word FIFO and commit/discard flush sequencing
module fifo_flush_pack
  import fifo_flush_pkg::*;
#(
  parameter int              IN_W    = 4,
  parameter int              OUT_W   = 32,
  parameter int              DEPTH   = 8,
  parameter logic [IN_W-1:0] PAD_VAL = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fifo_wr_valid_i,
  input  logic [IN_W-1:0]          fifo_wr_data_i,
  output logic                     fifo_wr_ready_o,
  output logic                     fifo_wr_drop_o,
  input  logic                     fifo_rd_valid_i,
  output logic [OUT_W-1:0]         fifo_rd_data_o,
  input  logic                     fifo_flush_i,
  input  logic                     fifo_flush_mode_i,
  output logic                     fifo_flush_done_o,
  output logic                     fifo_data_avail_o,
  output logic                     fifo_empty_o,
  output logic                     fifo_full_o,
  output logic [$clog2(DEPTH):0]   fifo_count_o
);

  localparam int                RATIO     = OUT_W / IN_W;
  localparam int                FILL_W    = $clog2(RATIO);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(RATIO - 1);

  flush_state_e      state_q, state_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [OUT_W-1:0]  pack_q, pack_d;

  logic              wr_ready;
  logic              pop_eff;
  logic              mem_full;
  logic              mem_empty;
  logic              mem_push;
  logic              mem_clr;
  logic [OUT_W-1:0]  mem_push_data;
  logic [OUT_W-1:0]  beat_word;
  logic [OUT_W-1:0]  pad_word;
  logic              flush_done;

  // A last beat with no room stalls the producer; a same-cycle pop deliberately does not help
  assign wr_ready          = (state_q == ST_IDLE) && !((fill_q == FILL_LAST) && mem_full);
  assign pop_eff           = fifo_rd_valid_i && !mem_empty;
  assign fifo_wr_ready_o   = wr_ready;
  assign fifo_wr_drop_o    = fifo_wr_valid_i && !wr_ready;
  assign fifo_flush_done_o = flush_done;
  assign fifo_empty_o      = mem_empty;
  assign fifo_full_o       = mem_full;
  assign fifo_data_avail_o = !mem_empty;

  // Packer word with the incoming beat dropped into lane fill_q (LSB lane first)
  always_comb begin
    beat_word = pack_q;
    for (int i = 0; i < RATIO; i++) begin
      if (FILL_W'(i) == fill_q) begin
        beat_word[i*IN_W +: IN_W] = fifo_wr_data_i;
      end
    end
  end

  // Partial packer word with every lane from fill_q upward forced to the pad value
  always_comb begin
    pad_word = pack_q;
    for (int i = 0; i < RATIO; i++) begin
      if (FILL_W'(i) >= fill_q) begin
        pad_word[i*IN_W +: IN_W] = PAD_VAL;
      end
    end
  end

  // Flush sequencer and packer next-state: write acceptance, flush sampling, padding and completion pulse
  always_comb begin
    state_d       = state_q;
    fill_d        = fill_q;
    pack_d        = pack_q;
    mem_push      = 1'b0;
    mem_push_data = beat_word;
    mem_clr       = 1'b0;
    flush_done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fifo_wr_valid_i && wr_ready) begin
          if (fill_q == FILL_LAST) begin
            mem_push = 1'b1;
            fill_d   = '0;
            pack_d   = '0;
          end else begin
            fill_d = fill_q + FILL_W'(1);
            pack_d = beat_word;
          end
        end
        // A beat accepted at the sampling edge belongs to the data being flushed
        if (fifo_flush_i) begin
          case (fifo_flush_mode_i)
            FLUSH_DISCARD: begin
              mem_clr  = 1'b1;
              mem_push = 1'b0;
              fill_d   = '0;
              pack_d   = '0;
              state_d  = ST_DONE;
            end
            FLUSH_COMMIT: begin
              state_d = (fill_d == '0) ? ST_DONE : ST_PAD;
            end
            default: state_d = ST_DONE;
          endcase
        end
      end
      ST_PAD: begin
        if (!mem_full || pop_eff) begin
          mem_push      = 1'b1;
          mem_push_data = pad_word;
          fill_d        = '0;
          pack_d        = '0;
          state_d       = ST_DONE;
        end
      end
      ST_DONE: begin
        flush_done = 1'b1;
        state_d    = ST_HOLD;
      end
      ST_HOLD: begin
        if (!fifo_flush_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, fill counter and packer registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      fill_q  <= '0;
      pack_q  <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      pack_q  <= pack_d;
    end
  end

  fifo_pack_mem #(
    .WIDTH (OUT_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk         (clk),
    .rst_n       (reset),
    .clr_i       (mem_clr),
    .push_i      (mem_push),
    .push_data_i (mem_push_data),
    .pop_i       (fifo_rd_valid_i),
    .rd_data_o   (fifo_rd_data_o),
    .empty_o     (mem_empty),
    .full_o      (mem_full),
    .count_o     (fifo_count_o)
  );

endmodule

// File: tb/tb_fifo_flush_pack.sv
// tb/tb_fifo_flush_pack.sv - self-checking bench for fifo_flush_pack against a queue-based reference model
module tb_fifo_flush_pack;

  localparam int              IN_W  = 4;
  localparam int              OUT_W = 32;
  localparam int              DEPTH = 8;
  localparam int              RATIO = OUT_W / IN_W;
  localparam int              CW    = $clog2(DEPTH) + 1;
  localparam logic [IN_W-1:0] PAD   = '0;

  localparam int P_IDLE = 0;
  localparam int P_PAD  = 1;
  localparam int P_DONE = 2;
  localparam int P_HOLD = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             wv;
  logic [IN_W-1:0]  wd;
  logic             rv;
  logic             fl;
  logic             fm;
  logic             ready_o;
  logic             drop_o;
  logic [OUT_W-1:0] rd_data_o;
  logic             done_o;
  logic             avail_o;
  logic             empty_o;
  logic             full_o;
  logic [CW-1:0]    count_o;

  int compared   = 0;
  int mismatched = 0;
  int done_seen  = 0;
  int d0;

  logic [OUT_W-1:0] m_words[$];
  logic [IN_W-1:0]  m_beats[$];
  int               m_phase;

  always #5 clk = ~clk;

  fifo_flush_pack #(
    .IN_W    (IN_W),
    .OUT_W   (OUT_W),
    .DEPTH   (DEPTH),
    .PAD_VAL (PAD)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .fifo_wr_valid_i   (wv),
    .fifo_wr_data_i    (wd),
    .fifo_wr_ready_o   (ready_o),
    .fifo_wr_drop_o    (drop_o),
    .fifo_rd_valid_i   (rv),
    .fifo_rd_data_o    (rd_data_o),
    .fifo_flush_i      (fl),
    .fifo_flush_mode_i (fm),
    .fifo_flush_done_o (done_o),
    .fifo_data_avail_o (avail_o),
    .fifo_empty_o      (empty_o),
    .fifo_full_o       (full_o),
    .fifo_count_o      (count_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_ready();
    return (m_phase == P_IDLE) && !((m_beats.size() == RATIO - 1) && (m_words.size() == DEPTH));
  endfunction

  function automatic logic [OUT_W-1:0] m_pack();
    logic [OUT_W-1:0] w;
    w = '0;
    for (int k = 0; k < RATIO; k++) begin
      w[k*IN_W +: IN_W] = (k < m_beats.size()) ? m_beats[k] : PAD;
    end
    return w;
  endfunction

  task automatic model_reset();
    m_words.delete();
    m_beats.delete();
    m_phase = P_IDLE;
  endtask

  task automatic model_edge();
    bit               pop;
    bit               acc;
    bit               have_w;
    logic [OUT_W-1:0] w;
    have_w = 1'b0;
    w      = '0;
    pop    = rv && (m_words.size() > 0);
    acc    = wv && m_ready();
    case (m_phase)
      P_IDLE: begin
        if (acc) begin
          m_beats.push_back(wd);
          if (m_beats.size() == RATIO) begin
            w      = m_pack();
            have_w = 1'b1;
            m_beats.delete();
          end
        end
        if (fl && fm) begin
          m_words.delete();
          m_beats.delete();
          m_phase = P_DONE;
        end else begin
          if (pop) void'(m_words.pop_front());
          if (have_w) m_words.push_back(w);
          if (fl) m_phase = (m_beats.size() == 0) ? P_DONE : P_PAD;
        end
      end
      P_PAD: begin
        if (pop) void'(m_words.pop_front());
        if (m_words.size() < DEPTH) begin
          m_words.push_back(m_pack());
          m_beats.delete();
          m_phase = P_DONE;
        end
      end
      P_DONE: begin
        if (pop) void'(m_words.pop_front());
        m_phase = P_HOLD;
      end
      default: begin
        if (pop) void'(m_words.pop_front());
        if (!fl) m_phase = P_IDLE;
      end
    endcase
  endtask

  task automatic check_outputs();
    check("ready", ready_o, m_ready());
    check("drop", drop_o, wv && !m_ready());
    check("done", done_o, m_phase == P_DONE);
    check("empty", empty_o, m_words.size() == 0);
    check("full", full_o, m_words.size() == DEPTH);
    check("avail", avail_o, m_words.size() != 0);
    check("count", count_o, m_words.size());
    if (m_words.size() != 0) check("rd_data", rd_data_o, m_words[0]);
    if (done_o) done_seen++;
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic step(input logic w, input logic [IN_W-1:0] d, input logic r, input logic f, input logic m);
    wv = w; wd = d; rv = r; fl = f; fm = m;
    cycle();
  endtask

  task automatic fill_beats(input int n);
    for (int i = 0; i < n; i++) step(1'b1, IN_W'($urandom_range(0, 15)), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_rd_data"}, rd_data_o, 0);
    check({pfx, "_avail"}, avail_o, 0);
    check({pfx, "_empty"}, empty_o, 1);
    check({pfx, "_full"}, full_o, 0);
    check({pfx, "_count"}, count_o, 0);
    check({pfx, "_done"}, done_o, 0);
    check({pfx, "_ready"}, ready_o, 1);
    check({pfx, "_drop"}, drop_o, 0);
  endtask

  initial begin
    reset = 1'b0; wv = 1'b0; wd = '0; rv = 1'b0; fl = 1'b0; fm = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("por");
    reset = 1'b1;

    // reset mid-word, then a clean 1..8 word
    fill_beats(3);
    wv = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_reset_values("midrst");
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 1; i <= 8; i++) step(1'b1, IN_W'(i), 1'b0, 1'b0, 1'b0);
    wv = 1'b0;
    #1;
    check("t1_head", rd_data_o, 32'h87654321);
    drain();

    // commit flush of a 3-beat partial word
    d0 = done_seen;
    step(1'b1, 4'hA, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'h6, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'h8, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("t2_done_pulses", done_seen - d0, 1);
    check("t2_head", rd_data_o, 32'h0000086A);
    check("t2_count", count_o, 1);
    drain();

    // full FIFO stalls the ninth word's last beat until a pop
    fill_beats(DEPTH * RATIO + RATIO - 1);
    wv = 1'b1; wd = 4'h5; rv = 1'b0; fl = 1'b0;
    #1;
    check("t3_full", full_o, 1);
    check("t3_ready", ready_o, 0);
    check("t3_drop", drop_o, 1);
    cycle();
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    wv = 1'b0;
    #1;
    check("t3_ready_after_pop", ready_o, 1);
    step(1'b1, 4'h5, 1'b0, 1'b0, 1'b0);
    check("t3_count", count_o, DEPTH);
    drain();

    // commit flush stalls in padding while full, released by one pop
    fill_beats(DEPTH * RATIO + 2);
    d0 = done_seen;
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("t4_no_done_while_full", done_seen - d0, 0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("t4_count", count_o, DEPTH);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("t4_done_pulses", done_seen - d0, 1);
    drain();

    // discard flush with a simultaneous read
    fill_beats(3 * RATIO + 2);
    d0 = done_seen;
    step(1'b0, '0, 1'b1, 1'b1, 1'b1);
    check("t5_empty", empty_o, 1);
    check("t5_count", count_o, 0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("t5_done_pulses", done_seen - d0, 1);
    for (int i = 0; i < 8; i++) step(1'b1, IN_W'(15 - i), 1'b0, 1'b0, 1'b0);
    check("t5_count_after", count_o, 1);
    check("t5_head", rd_data_o, 32'h89ABCDEF);
    drain();

    // flush held high with nothing pending
    d0 = done_seen;
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, IN_W'($urandom_range(0, 15)), 1'b0, 1'b1, 1'b0);
    step(1'b1, IN_W'($urandom_range(0, 15)), 1'b0, 1'b0, 1'b0);
    wv = 1'b0;
    #1;
    check("t6_ready_back", ready_o, 1);
    check("t6_done_pulses", done_seen - d0, 1);
    check("t6_count", count_o, 0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 99) < 70), IN_W'($urandom_range(0, 15)),
           ($urandom_range(0, 99) < 40), ($urandom_range(0, 99) < 4), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
